// File: rtl/ex_muldiv_unit_if.sv
// Start/busy/done handshake and operand/result bundle between the EX stage
// and ex_muldiv_unit. The EX stage drives the master side, the unit the slave side.
interface ex_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              cancel_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              div_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i, cancel_i,
        input  busy_o, done_o, hi_o, lo_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, cancel_i,
        output busy_o, done_o, hi_o, lo_o, div_zero_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit with MIPS-style {hi,lo} result.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU complete at once with zero results.
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);
    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate of a DATA_W word when neg is set
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
        logic [DATA_W-1:0] r;
        if (neg) begin
            r = ~x + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Two's-complement negate of a double-width product when neg is set
    function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] x, input logic neg);
        logic [2*DATA_W-1:0] r;
        if (neg) begin
            r = ~x + {{(2*DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]   mq_r;
    logic [DATA_W-1:0]   opd_r;
    logic                neg_r;
`ifdef MULDIV_DIV_EN
    logic                is_div_r;
    logic                sign_a_r;
    logic [DATA_W:0]     div_shift_s;
    logic                div_ge_s;
    logic [DATA_W-1:0]   div_diff_s;
`endif
    logic                accept_s;
    logic                bypass_s;
    logic                req_signed_s;
    logic                req_sa_s;
    logic                req_sb_s;
    logic [DATA_W:0]     mul_sum_s;
    logic [DATA_W-1:0]   mul_acc_s;
    logic [DATA_W-1:0]   mul_mq_s;
    logic [DATA_W-1:0]   step_acc_s;
    logic [DATA_W-1:0]   step_mq_s;
    logic [2*DATA_W-1:0] fix_prod_s;
    logic [DATA_W-1:0]   fix_hi_s;
    logic [DATA_W-1:0]   fix_lo_s;
    logic                busy_r;
    logic                done_r;
    logic                dz_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                dz_nxt_s;
    logic [DATA_W-1:0]   hi_nxt_s;
    logic [DATA_W-1:0]   lo_nxt_s;

    // Request decode: acceptance, operand signs and the no-iteration bypass
    always_comb begin
        accept_s     = (state_r == ST_IDLE) & bus.start_i & ~bus.cancel_i;
        req_signed_s = ~bus.op_i[0];
        req_sa_s     = req_signed_s & bus.a_i[DATA_W-1];
        req_sb_s     = req_signed_s & bus.b_i[DATA_W-1];
`ifdef MULDIV_DIV_EN
        bypass_s     = accept_s & bus.op_i[1] & (bus.b_i == ZERO_W);
`else
        bypass_s     = accept_s & bus.op_i[1];
`endif
    end

    // One iteration: shift-add multiply or restoring divide on the magnitudes
    always_comb begin
        mul_sum_s = {1'b0, acc_r} + (mq_r[0] ? {1'b0, opd_r} : {(DATA_W+1){1'b0}});
        mul_acc_s = mul_sum_s[DATA_W:1];
        mul_mq_s  = {mul_sum_s[0], mq_r[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
        // Partial remainder stays below the divisor, so the W-bit difference is exact
        div_shift_s = {acc_r, mq_r[DATA_W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opd_r});
        div_diff_s  = div_shift_s[DATA_W-1:0] - opd_r;
        if (is_div_r) begin
            step_acc_s = div_ge_s ? div_diff_s : div_shift_s[DATA_W-1:0];
            step_mq_s  = {mq_r[DATA_W-2:0], div_ge_s};
        end else begin
            step_acc_s = mul_acc_s;
            step_mq_s  = mul_mq_s;
        end
`else
        step_acc_s = mul_acc_s;
        step_mq_s  = mul_mq_s;
`endif
    end

    // Sign correction applied when leaving FIX
    always_comb begin
        fix_prod_s = cond_neg2({acc_r, mq_r}, neg_r);
`ifdef MULDIV_DIV_EN
        if (is_div_r) begin
            fix_hi_s = cond_neg(acc_r, sign_a_r);
            fix_lo_s = cond_neg(mq_r, neg_r);
        end else begin
            fix_hi_s = fix_prod_s[2*DATA_W-1:DATA_W];
            fix_lo_s = fix_prod_s[DATA_W-1:0];
        end
`else
        fix_hi_s = fix_prod_s[2*DATA_W-1:DATA_W];
        fix_lo_s = fix_prod_s[DATA_W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; cancel aborts RUN/FIX but never a DONE pulse
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = bypass_s ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.cancel_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (bus.cancel_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values for the next cycle; results only move on entry to DONE
    always_comb begin
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
        hi_nxt_s   = hi_r;
        lo_nxt_s   = lo_r;
        dz_nxt_s   = 1'b0;
        if ((state_r == ST_FIX) && (state_nxt_s == ST_DONE)) begin
            hi_nxt_s = fix_hi_s;
            lo_nxt_s = fix_lo_s;
        end else if (bypass_s) begin
`ifdef MULDIV_DIV_EN
            hi_nxt_s = bus.a_i;
            lo_nxt_s = {DATA_W{1'b1}};
            dz_nxt_s = 1'b1;
`else
            hi_nxt_s = ZERO_W;
            lo_nxt_s = ZERO_W;
            dz_nxt_s = 1'b0;
`endif
        end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= ZERO_W;
            lo_r   <= ZERO_W;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            dz_r   <= dz_nxt_s;
            hi_r   <= hi_nxt_s;
            lo_r   <= lo_nxt_s;
        end
    end

    // Iteration datapath: operand capture on accept, one step per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= ZERO_W;
            mq_r     <= ZERO_W;
            opd_r    <= ZERO_W;
            neg_r    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_r <= 1'b0;
            sign_a_r <= 1'b0;
`endif
        end else if (accept_s) begin
            // |MIN| lands as unsigned 2^(W-1), which the W-bit magnitude holds exactly
            cnt_r    <= CNT_INIT;
            acc_r    <= ZERO_W;
            mq_r     <= cond_neg(bus.a_i, req_sa_s);
            opd_r    <= cond_neg(bus.b_i, req_sb_s);
            neg_r    <= req_sa_s ^ req_sb_s;
`ifdef MULDIV_DIV_EN
            is_div_r <= bus.op_i[1];
            sign_a_r <= req_sa_s;
`endif
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r - CNT_ONE;
            acc_r <= step_acc_s;
            mq_r  <= step_mq_s;
        end
    end

    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.hi_o       = hi_r;
    assign bus.lo_o       = lo_r;
    assign bus.div_zero_o = dz_r;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases, then random ops
// compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
    localparam int DW = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.DATA_W(DW)) bus ();

    ex_muldiv_unit #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, SV truncating division
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sr;
        logic [63:0]        ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        dz = 1'b0;
        hi = 32'h0;
        lo = 32'h0;
        case (op)
            2'b00: begin sr = sa * sb; hi = sr[63:32]; lo = sr[31:0]; end
            2'b01: begin ur = {32'h0, a} * {32'h0, b}; hi = ur[63:32]; lo = ur[31:0]; end
            default: begin
                if (DIV_EN) begin
                    if (b == 32'h0) begin
                        hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                    end else if (op == 2'b10) begin
                        sr = sa / sb; lo = sr[31:0];
                        sr = sa % sb; hi = sr[31:0];
                    end else begin
                        lo = a / b; hi = a % b;
                    end
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mid_k, input bit start_in_done);
        logic [31:0] ehi, elo;
        logic        edz;
        int          k, lat_exp;
        bit          seen, quiet_ok;
        ref_model(op, a, b, ehi, elo, edz);
        lat_exp = (op[1] && (!DIV_EN || b == 32'h0)) ? 1 : DW + 2;
        @(negedge clk);
        bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        k = 0; seen = 1'b0; quiet_ok = 1'b1;
        while (!seen && k < 200) begin
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.busy_o !== 1'b1 || bus.hi_o !== prev_hi || bus.lo_o !== prev_lo ||
                    bus.div_zero_o !== 1'b0) quiet_ok = 1'b0;
                if (k == mid_k) begin bus.start_i = 1'b1; bus.op_i = ~op; end
                @(posedge clk); #1;
                bus.start_i = 1'b0; bus.op_i = op;
                k++;
            end
        end
        check({tag, ".done_seen"}, 64'(seen), 64'(1));
        check({tag, ".latency"}, 64'(k + 1), 64'(lat_exp));
        check({tag, ".quiet_while_busy"}, 64'(quiet_ok), 64'(1));
        check({tag, ".hi"}, 64'(bus.hi_o), 64'(ehi));
        check({tag, ".lo"}, 64'(bus.lo_o), 64'(elo));
        check({tag, ".div_zero"}, 64'(bus.div_zero_o), 64'(edz));
        check({tag, ".busy_in_done"}, 64'(bus.busy_o), 64'(1));
        prev_hi = ehi; prev_lo = elo;
        if (start_in_done) bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        check({tag, ".done_pulse_end"}, 64'(bus.done_o), 64'(0));
        check({tag, ".idle_after"}, 64'(bus.busy_o), 64'(0));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bit          no_done;
        bus.start_i = 1'b0; bus.cancel_i = 1'b0; bus.op_i = 2'b00;
        bus.a_i = 32'h0; bus.b_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 64'(bus.busy_o), 64'(0));
        check("rst.done", 64'(bus.done_o), 64'(0));
        check("rst.hi", 64'(bus.hi_o), 64'(0));
        check("rst.lo", 64'(bus.lo_o), 64'(0));
        check("rst.div_zero", 64'(bus.div_zero_o), 64'(0));
        rst = 1'b0;

        // Directed cases
        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h7, -1, 1'b0);
        run_op("multu_max_midstart", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, -1, 1'b0);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1);
        run_op("divu_by_zero", 2'b11, 32'h64, 32'h0, -1, 1'b0);
        run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
        run_op("divu_9_3", 2'b11, 32'h9, 32'h3, -1, 1'b0);

        // Start together with cancel in IDLE is dropped
        @(negedge clk);
        bus.start_i = 1'b1; bus.cancel_i = 1'b1; bus.op_i = 2'b01; bus.a_i = 32'h3; bus.b_i = 32'h4;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.cancel_i = 1'b0;
        check("idle_cancel.busy", 64'(bus.busy_o), 64'(0));

        // Cancel mid-op: MULTU 5*6 flushed at edge 10
        @(negedge clk);
        bus.op_i = 2'b01; bus.a_i = 32'h5; bus.b_i = 32'h6; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.cancel_i = 1'b1;
        @(posedge clk); #1;
        bus.cancel_i = 1'b0;
        check("cancel.busy", 64'(bus.busy_o), 64'(0));
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o !== 1'b0) no_done = 1'b0;
            @(posedge clk); #1;
        end
        check("cancel.no_done", 64'(no_done), 64'(1));
        check("cancel.hi_kept", 64'(bus.hi_o), 64'(prev_hi));
        check("cancel.lo_kept", 64'(bus.lo_o), 64'(prev_lo));
        run_op("multu_5x6_rerun", 2'b01, 32'h5, 32'h6, -1, 1'b0);

        // Reset in the middle of RUN
        @(negedge clk);
        bus.op_i = 2'b00; bus.a_i = 32'h1234_5678; bus.b_i = 32'h9; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.busy", 64'(bus.busy_o), 64'(0));
        check("midrst.done", 64'(bus.done_o), 64'(0));
        check("midrst.hi", 64'(bus.hi_o), 64'(0));
        check("midrst.lo", 64'(bus.lo_o), 64'(0));
        check("midrst.div_zero", 64'(bus.div_zero_o), 64'(0));
        prev_hi = 32'h0; prev_lo = 32'h0;

        // Random operations biased toward sign and zero corners
        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(3, 0));
            case ($urandom_range(5, 0))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(6, 0))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h1;
                3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op("random", rop, ra, rb, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
